// File: rtl/led_pulse_stretcher_if.sv
// rtl/led_pulse_stretcher_if.sv - event/status bundle between the event source and the LED pulse stretcher
interface led_pulse_stretcher_if #(
   parameter int MAX_PENDING = 15
);
   localparam int PEND_W = $clog2(MAX_PENDING + 1);

   logic              event_in;
   logic              clr_overflow;
   logic              led_out;
   logic              busy;
   logic [PEND_W-1:0] pending_cnt;
   logic              overflow;

   modport master (
      output event_in,
      output clr_overflow,
      input  led_out,
      input  busy,
      input  pending_cnt,
      input  overflow
   );

   modport slave (
      input  event_in,
      input  clr_overflow,
      output led_out,
      output busy,
      output pending_cnt,
      output overflow
   );
endinterface

// File: rtl/led_pulse_stretcher.sv
// rtl/led_pulse_stretcher.sv - one clean LED blink per event with minimum on/off times
// Define LED_PENDING_QUEUE_EN to queue events that arrive mid-blink instead of dropping them.
module led_pulse_stretcher #(
   parameter int ON_TIME     = 5000000,
   parameter int OFF_TIME    = 5000000,
   parameter int MAX_PENDING = 15
) (
   input logic                  clk,
   input logic                  rst_n,
   led_pulse_stretcher_if.slave bus
);
   localparam int PEND_W  = $clog2(MAX_PENDING + 1);
   localparam int T_MAX   = (ON_TIME > OFF_TIME) ? ON_TIME : OFF_TIME;
   localparam int TIMER_W = $clog2(T_MAX + 1);
   localparam logic [TIMER_W-1:0] ON_LAST  = TIMER_W'(ON_TIME - 1);
   localparam logic [TIMER_W-1:0] OFF_LAST = TIMER_W'(OFF_TIME - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               led_q;
   logic               ovf_q;
   logic               ovf_set;
   logic               ev_busy;
   logic               gap_last;
   logic               replay;

   assign ev_busy  = bus.event_in && (state_q != IDLE);
   assign gap_last = (state_q == GAP) && (timer_q == OFF_LAST);

`ifdef LED_PENDING_QUEUE_EN
   logic [PEND_W-1:0] pend_q, pend_d;
   logic              consume;

   // An event landing in the last gap cycle restarts the LED directly, so it counts as a replay source.
   assign replay  = (pend_q != '0) || bus.event_in;
   assign consume = gap_last && replay;

   always_comb begin
      pend_d  = pend_q;
      ovf_set = 1'b0;
      if (ev_busy && !consume) begin
         if (pend_q == PEND_W'(MAX_PENDING)) begin
            ovf_set = 1'b1;
         end else begin
            pend_d = pend_q + PEND_W'(1);
         end
      end else if (consume && !ev_busy) begin
         pend_d = pend_q - PEND_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   assign bus.pending_cnt = pend_q;
`else
   assign replay          = 1'b0;
   assign ovf_set         = ev_busy;
   assign bus.pending_cnt = '0;
`endif

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      unique case (state_q)
         IDLE: begin
            if (bus.event_in) begin
               state_d = ON;
               timer_d = '0;
            end
         end
         ON: begin
            if (timer_q == ON_LAST) begin
               state_d = GAP;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         GAP: begin
            if (gap_last) begin
               state_d = replay ? ON : IDLE;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            timer_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         timer_q <= '0;
         led_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         led_q   <= (state_d == ON);
         // A fresh loss outranks a coincident clear.
         if (ovf_set) begin
            ovf_q <= 1'b1;
         end else if (bus.clr_overflow) begin
            ovf_q <= 1'b0;
         end
      end
   end

   assign bus.led_out  = led_q;
   assign bus.busy     = (state_q != IDLE);
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_led_pulse_stretcher.sv
// tb/tb_led_pulse_stretcher.sv - scoreboard bench for led_pulse_stretcher (ON_TIME=4, OFF_TIME=3, MAX_PENDING=2)
module tb_led_pulse_stretcher;
   localparam int ON_T  = 4;
   localparam int OFF_T = 3;
   localparam int MAX_P = 2;

   typedef struct {
      int led;
      int busy;
      int pend;
      int ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   led_pulse_stretcher_if #(.MAX_PENDING(MAX_P)) bus ();

   led_pulse_stretcher #(
      .ON_TIME    (ON_T),
      .OFF_TIME   (OFF_T),
      .MAX_PENDING(MAX_P)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   m_state = 0;
   int   m_left  = 0;
   int   m_pend  = 0;
   int   m_ovf   = 0;
   int   led_cnt = 0;
   int   busy_cnt = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit enqueue();
`ifdef LED_PENDING_QUEUE_EN
      if (m_pend == MAX_P) return 1'b1;
      m_pend++;
      return 1'b0;
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_step(input bit ev, input bit clr);
      exp_t e;
      bit   lost = 1'b0;
      case (m_state)
         0: begin
            if (ev) begin
               m_state = 1;
               m_left  = ON_T;
            end
         end
         1: begin
            if (ev) lost = enqueue();
            m_left--;
            if (m_left == 0) begin
               m_state = 2;
               m_left  = OFF_T;
            end
         end
         default: begin
            m_left--;
            if (m_left == 0) begin
`ifdef LED_PENDING_QUEUE_EN
               if (ev) begin
                  m_state = 1;
                  m_left  = ON_T;
               end else if (m_pend > 0) begin
                  m_pend--;
                  m_state = 1;
                  m_left  = ON_T;
               end else begin
                  m_state = 0;
               end
`else
               if (ev) lost = 1'b1;
               m_state = 0;
`endif
            end else if (ev) begin
               lost = enqueue();
            end
         end
      endcase
      if (lost) m_ovf = 1;
      else if (clr) m_ovf = 0;
      e.led  = (m_state == 1) ? 1 : 0;
      e.busy = (m_state != 0) ? 1 : 0;
      e.pend = m_pend;
      e.ovf  = m_ovf;
      sb.push_back(e);
   endtask

   task automatic tick(input bit ev, input bit clr);
      exp_t e;
      bus.event_in     = ev;
      bus.clr_overflow = clr;
      model_step(ev, clr);
      @(posedge clk);
      #1;
      bus.event_in     = 1'b0;
      bus.clr_overflow = 1'b0;
      e = sb.pop_front();
      check("led_out", int'(bus.led_out), e.led);
      check("busy", int'(bus.busy), e.busy);
      check("pending_cnt", int'(bus.pending_cnt), e.pend);
      check("overflow", int'(bus.overflow), e.ovf);
      if (bus.led_out) led_cnt++;
      if (bus.busy) busy_cnt++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
   endtask

   task automatic model_reset();
      m_state = 0;
      m_left  = 0;
      m_pend  = 0;
      m_ovf   = 0;
      sb.delete();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_led"}, int'(bus.led_out), 0);
      check({tag, "_busy"}, int'(bus.busy), 0);
      check({tag, "_pend"}, int'(bus.pending_cnt), 0);
      check({tag, "_ovf"}, int'(bus.overflow), 0);
   endtask

   task automatic clear_counts();
      led_cnt  = 0;
      busy_cnt = 0;
   endtask

   initial begin
      bus.event_in     = 1'b0;
      bus.clr_overflow = 1'b0;
      rst_n            = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      model_reset();
      idle(3);

      // single event
      clear_counts();
      tick(1'b1, 1'b0);
      idle(12);
      check("single_led_cycles", led_cnt, ON_T);
      check("single_busy_cycles", busy_cnt, ON_T + OFF_T);

      // second event during ON
      clear_counts();
      tick(1'b1, 1'b0);
      idle(1);
      tick(1'b1, 1'b0);
      idle(20);
`ifdef LED_PENDING_QUEUE_EN
      check("two_led_cycles", led_cnt, 2 * ON_T);
`else
      check("two_led_cycles", led_cnt, ON_T);
`endif
      tick(1'b0, 1'b1);

      // burst past saturation, then clear, then clear coincident with a drop
      clear_counts();
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      check("burst_ovf", int'(bus.overflow), 1);
      idle(30);
`ifdef LED_PENDING_QUEUE_EN
      check("burst_led_cycles", led_cnt, 3 * ON_T);
`else
      check("burst_led_cycles", led_cnt, ON_T);
`endif
      check("burst_ovf_sticky", int'(bus.overflow), 1);
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b0);
      idle(1);
      tick(1'b1, 1'b1);
      idle(30);
      tick(1'b0, 1'b1);

      // event on the last gap cycle
      clear_counts();
      tick(1'b1, 1'b0);
      idle(6);
      tick(1'b1, 1'b0);
      idle(12);
`ifdef LED_PENDING_QUEUE_EN
      check("lastgap_led_cycles", led_cnt, 2 * ON_T);
      check("lastgap_busy_cycles", busy_cnt, 2 * (ON_T + OFF_T));
`else
      check("lastgap_led_cycles", led_cnt, ON_T);
`endif
      tick(1'b0, 1'b1);

      // asynchronous reset mid-ON with a queued event
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_counts();
      idle(15);
      check("post_rst_led_cycles", led_cnt, 0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         tick(($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0));
      end
      idle(40);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
